// File: rtl/pixel_row_readout_pkg.sv
// rtl/pixel_row_readout_pkg.sv - shared sensor readout configuration: beat math, pixel types, read FSM states
//
// Purpose: constants, typedefs and helper functions shared by the row readout
//          buffer and its row FIFO.
// Contents:
//   DEF_PIXEL_BITS / DEF_BUS_WIDTH - default sensor configuration
//   pixel_t, beat_t                - pixel and output-beat types for the defaults
//   readout_state_t                - read-side FSM encoding
//   calc_beats, calc_last_lanes    - beats per row and pixels in the final beat
package pixel_row_readout_pkg;

    localparam int DEF_PIXEL_BITS = 8;
    localparam int DEF_BUS_WIDTH  = 8;

    typedef logic [DEF_PIXEL_BITS-1:0]               pixel_t;
    typedef logic [DEF_BUS_WIDTH*DEF_PIXEL_BITS-1:0] beat_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } readout_state_t;

    // Number of bus beats needed to carry one row (ceiling division).
    function automatic int calc_beats(input int row_width, input int bus_width);
        return (row_width + bus_width - 1) / bus_width;
    endfunction

    // Pixels carried by the final beat of a row (1..bus_width).
    function automatic int calc_last_lanes(input int row_width, input int bus_width);
        return row_width - (calc_beats(row_width, bus_width) - 1) * bus_width;
    endfunction

endpackage

// File: rtl/pixel_row_readout_row_fifo.sv
// rtl/pixel_row_readout_row_fifo.sv - register FIFO holding whole pixel rows
//
// Purpose: DEPTH x WIDTH register FIFO with push/pop and an occupancy count.
//          Exposes the head row and the row behind it so the reader can move
//          straight onto the next row without a bubble.
// Ports:
//   clk, reset_n - clock, asynchronous active-low reset
//   push, wdata  - write one row (caller guarantees not full)
//   pop          - retire the head row (caller guarantees not empty)
//   head_data    - oldest row
//   next_data    - row behind the head (valid when count >= 2)
//   count        - number of rows held
module row_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 192
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             head_data,
    output logic [WIDTH-1:0]             next_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    rd_next;
    logic [CW-1:0]    count_q;

    // DEPTH is a power of two, so pointer increments wrap naturally.
    assign rd_next = rd_ptr_q + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_next;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign next_data = mem_q[rd_next];
    assign count     = count_q;

endmodule

// File: rtl/pixel_row_readout.sv
// rtl/pixel_row_readout.sv - row-to-bus readout buffer with frame/row markers
//
// Purpose: accepts whole pixel rows, buffers up to ROW_DEPTH of them and
//          streams each row as OUTPUT_BUS_WIDTH-pixel beats with valid/ready.
// Ports:
//   clk, reset_n                 - clock, asynchronous active-low reset
//   row_valid/row_ready/row_data - row input handshake, pixel 0 in LSBs
//   out_valid/out_ready/out_data - beat output handshake, lowest column in LSBs
//   out_lane_mask                - 1 per lane carrying a real pixel
//   out_frame_start              - row 0, beat 0
//   out_row_end / out_frame_end  - last beat of a row / of the last row
//   overflow / clear_overflow    - sticky dropped-row flag and its clear
module pixel_row_readout
    import pixel_row_readout_pkg::*;
#(
    parameter int PIXEL_ARRAY_WIDTH  = 24,
    parameter int PIXEL_ARRAY_HEIGHT = 12,
    parameter int PIXEL_BITS         = 8,
    parameter int OUTPUT_BUS_WIDTH   = 8,
    parameter int ROW_DEPTH          = 2
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   row_valid,
    output logic                                   row_ready,
    input  logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0] row_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [OUTPUT_BUS_WIDTH*PIXEL_BITS-1:0] out_data,
    output logic [OUTPUT_BUS_WIDTH-1:0]            out_lane_mask,
    output logic                                   out_frame_start,
    output logic                                   out_row_end,
    output logic                                   out_frame_end,
    output logic                                   overflow,
    input  logic                                   clear_overflow
);

    localparam int BEATS      = calc_beats(PIXEL_ARRAY_WIDTH, OUTPUT_BUS_WIDTH);
    localparam int LAST_LANES = calc_last_lanes(PIXEL_ARRAY_WIDTH, OUTPUT_BUS_WIDTH);
    localparam int ROW_W      = PIXEL_ARRAY_WIDTH * PIXEL_BITS;
    localparam int BEAT_W     = OUTPUT_BUS_WIDTH * PIXEL_BITS;
    localparam int PAD_W      = BEATS * BEAT_W;
    localparam int BW         = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int RW         = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1;
    localparam int CW         = $clog2(ROW_DEPTH + 1);

    localparam logic [OUTPUT_BUS_WIDTH-1:0] FULL_MASK = '1;
    localparam logic [OUTPUT_BUS_WIDTH-1:0] LAST_MASK = FULL_MASK >> (OUTPUT_BUS_WIDTH - LAST_LANES);
    localparam logic [BW-1:0]               LAST_BEAT = BW'(BEATS - 1);
    localparam logic [RW-1:0]               LAST_ROW  = RW'(PIXEL_ARRAY_HEIGHT - 1);

    readout_state_t         state_q, state_d;
    logic [BW-1:0]          beat_q, beat_d;
    logic [RW-1:0]          row_q, row_d;
    logic                   ovf_q, ovf_d;
    logic                   valid_q, valid_d;
    logic [BEAT_W-1:0]      data_q, data_d;
    logic [OUTPUT_BUS_WIDTH-1:0] mask_q, mask_d;
    logic                   fs_q, fs_d;
    logic                   re_q, re_d;
    logic                   fe_q, fe_d;

    logic                   push;
    logic                   pop;
    logic [ROW_W-1:0]       head_data;
    logic [ROW_W-1:0]       next_data;
    logic [CW-1:0]          count;

    // Beat loader controls from the FSM.
    logic                   load;
    logic [ROW_W-1:0]       src_row;
    logic [BW-1:0]          load_beat;
    logic [RW-1:0]          load_row;
    logic [PAD_W-1:0]       padded_row;

    // Ready comes from the registered count only; a pop in the same cycle does
    // not free a slot, keeping row_ready off any combinational path.
    assign row_ready = (count < CW'(ROW_DEPTH));
    assign push      = row_valid && row_ready;

    row_fifo #(
        .DEPTH (ROW_DEPTH),
        .WIDTH (ROW_W)
    ) u_row_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .pop       (pop),
        .wdata     (row_data),
        .head_data (head_data),
        .next_data (next_data),
        .count     (count)
    );

    // Read-side FSM: chooses which row/beat to place in the output register.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        row_d     = row_q;
        valid_d   = valid_q;
        pop       = 1'b0;
        load      = 1'b0;
        src_row   = head_data;
        load_beat = beat_q;
        load_row  = row_q;

        case (state_q)
            IDLE: begin
                if (count != '0) begin
                    load    = 1'b1;
                    valid_d = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (beat_q != LAST_BEAT) begin
                        beat_d    = beat_q + 1'b1;
                        load      = 1'b1;
                        load_beat = beat_d;
                    end else begin
                        pop       = 1'b1;
                        beat_d    = '0;
                        row_d     = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
                        load_beat = '0;
                        load_row  = row_d;
                        if (count > CW'(1)) begin
                            load    = 1'b1;
                            src_row = next_data;
                        end else if (push) begin
                            // Last held row leaves as a new one arrives: take
                            // the incoming row directly to avoid a bubble.
                            load    = 1'b1;
                            src_row = row_data;
                        end else begin
                            valid_d = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // Beat formatter: zero-pad the row to a whole number of beats so lanes past
    // the row width read as 0, then slice out the selected beat.
    always_comb begin
        padded_row              = '0;
        padded_row[ROW_W-1:0]   = src_row;
        data_d                  = data_q;
        mask_d                  = mask_q;
        fs_d                    = fs_q;
        re_d                    = re_q;
        fe_d                    = fe_q;
        if (load) begin
            data_d = padded_row[int'(load_beat)*BEAT_W +: BEAT_W];
            mask_d = (load_beat == LAST_BEAT) ? LAST_MASK : FULL_MASK;
            fs_d   = (load_row == '0) && (load_beat == '0);
            re_d   = (load_beat == LAST_BEAT);
            fe_d   = (load_beat == LAST_BEAT) && (load_row == LAST_ROW);
        end
    end

    // A new drop sets the flag even when a clear arrives in the same cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (row_valid && !row_ready) begin
            ovf_d = 1'b1;
        end else if (clear_overflow) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            row_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            mask_q  <= '0;
            fs_q    <= 1'b0;
            re_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            row_q   <= row_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            fs_q    <= fs_d;
            re_q    <= re_d;
            fe_q    <= fe_d;
        end
    end

    assign out_valid       = valid_q;
    assign out_data        = data_q;
    assign out_lane_mask   = mask_q;
    assign out_frame_start = fs_q;
    assign out_row_end     = re_q;
    assign out_frame_end   = fe_q;
    assign overflow        = ovf_q;

endmodule
